// File: rtl/oled_glyph_sequencer_pkg.sv
// Shared types and constants for the OLED glyph sequencer: FSM states,
// SSD1306 command bases and the per-glyph width lookup.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_PAGE = 3'd1,
    CMD_COLL = 3'd2,
    CMD_COLH = 3'd3,
    FETCH    = 3'd4,
    DATA     = 3'd5,
    DONE     = 3'd6
  } state_e;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COLL_BASE = 8'h00;
  localparam logic [7:0] CMD_COLH_BASE = 8'h10;
  localparam logic [5:0] GLYPH_MAX     = 6'd14;

  // Digits and a few wide symbols are 16 columns; everything else is 8.
  function automatic logic [4:0] glyph_width(input logic [5:0] font_sel);
    if ((font_sel >= 6'd4 && font_sel <= 6'd9) || font_sel == 6'd11) begin
      return 5'd16;
    end
    return 5'd8;
  endfunction

endpackage

// File: rtl/oled_glyph_sequencer_if.sv
// Request and byte-stream bundle of the glyph sequencer.
// Optional req_invert exists only when OLED_INVERT_EN is defined.
interface oled_glyph_sequencer_if;
  // Both channels use valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; once valid is raised, valid and payload
  // stay stable until that edge (only reset may drop valid early).
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_font_sel;
  logic [2:0] req_page;
  logic [6:0] req_col;
`ifdef OLED_INVERT_EN
  logic       req_invert;
`endif
  logic       out_valid;
  logic       out_ready;
  logic       out_dc;
  logic [7:0] out_byte;

  modport master (
    input  req_valid, req_font_sel, req_page, req_col,
`ifdef OLED_INVERT_EN
    input  req_invert,
`endif
    output req_ready,
    output out_valid, out_dc, out_byte,
    input  out_ready
  );

  modport slave (
    output req_valid, req_font_sel, req_page, req_col,
`ifdef OLED_INVERT_EN
    output req_invert,
`endif
    input  req_ready,
    input  out_valid, out_dc, out_byte,
    output out_ready
  );
endinterface

// File: rtl/oled_glyph_sequencer.sv
// Walks one glyph through the font ROM and emits SSD1306 page/column commands
// followed by glyph bytes. OLED_INVERT_EN adds reverse-video data bytes.
module oled_glyph_sequencer
  import oled_pkg::*;
#(
  parameter int PAGE_COUNT  = 8,
  parameter int COL_COUNT   = 128,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  oled_glyph_sequencer_if.master        bus,
  output logic                          rom_font_row,
  output logic [5:0]                    rom_font_sel,
  output logic [8:0]                    rom_index,
  input  logic [7:0]                    rom_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output state_e                        dbg_state
);

  localparam logic [8:0] COL_LIM  = 9'(COL_COUNT);
  localparam logic [4:0] PAGE_LIM = 5'(PAGE_COUNT);
  localparam logic [1:0] LAT      = 2'(ROM_LATENCY);

  state_e     state_q, state_d;
  state_e     after_q, after_d;
  logic [5:0] font_q, font_d;
  logic [2:0] page_q, page_d;
  logic [6:0] col_q, col_d;
  logic       row_q, row_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       out_dc_q, out_dc_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       err_q, err_d;
`ifdef OLED_INVERT_EN
  logic       inv_q, inv_d;
`endif

  logic [4:0] width;
  logic       last_col;
  logic [8:0] col_sum;
  logic       emit;
  logic       row1_ok;
  logic [7:0] pg1_cmd;
  logic [7:0] data_byte;
  state_e     nxt;

  always_comb begin
    width     = glyph_width(font_q);
    last_col  = ({1'b0, idx_q} == (width - 5'd1));
    col_sum   = {2'b00, col_q} + {5'b00000, idx_q};
    emit      = (col_sum < COL_LIM);
    row1_ok   = (({2'b00, page_q} + 5'd1) < PAGE_LIM);
    pg1_cmd   = CMD_PAGE_BASE | {4'b0000, ({1'b0, page_q} + 4'd1)};
`ifdef OLED_INVERT_EN
    data_byte = inv_q ? ~rom_data : rom_data;
`else
    data_byte = rom_data;
`endif
  end

  always_comb begin
    state_d     = state_q;
    after_d     = after_q;
    font_d      = font_q;
    page_d      = page_q;
    col_d       = col_q;
    row_d       = row_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_dc_d    = out_dc_q;
    out_byte_d  = out_byte_q;
    err_d       = 1'b0;
    nxt         = FETCH;
`ifdef OLED_INVERT_EN
    inv_d       = inv_q;
`endif
    // Cycles since the ROM address last changed; saturates once past any latency.
    cnt_d       = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          font_d = bus.req_font_sel;
          page_d = bus.req_page;
          col_d  = bus.req_col;
          row_d  = 1'b0;
          idx_d  = 4'd0;
          cnt_d  = 2'd0;
`ifdef OLED_INVERT_EN
          inv_d  = bus.req_invert;
`endif
          if (bus.req_font_sel > GLYPH_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d     = CMD_PAGE;
            out_valid_d = 1'b1;
            out_dc_d    = 1'b0;
            out_byte_d  = CMD_PAGE_BASE | {5'b00000, bus.req_page};
          end
        end
      end
      CMD_PAGE: begin
        if (bus.out_ready) begin
          state_d    = CMD_COLL;
          out_byte_d = CMD_COLL_BASE | {4'b0000, col_q[3:0]};
        end
      end
      CMD_COLL: begin
        if (bus.out_ready) begin
          state_d    = CMD_COLH;
          out_byte_d = CMD_COLH_BASE | {5'b00000, col_q[6:4]};
        end
      end
      CMD_COLH: begin
        if (bus.out_ready) begin
          state_d     = FETCH;
          out_valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (cnt_q >= LAT) begin
          // The address advances as soon as the byte is captured, so the ROM
          // already works on the next column while this byte is offered.
          cnt_d = 2'd0;
          if (!last_col) begin
            nxt   = FETCH;
            idx_d = idx_q + 4'd1;
          end else if (!row_q && row1_ok) begin
            nxt   = CMD_PAGE;
            row_d = 1'b1;
            idx_d = 4'd0;
          end else begin
            nxt   = DONE;
          end
          if (emit) begin
            state_d     = DATA;
            after_d     = nxt;
            out_valid_d = 1'b1;
            out_dc_d    = 1'b1;
            out_byte_d  = data_byte;
          end else begin
            state_d = nxt;
            if (nxt == CMD_PAGE) begin
              out_valid_d = 1'b1;
              out_dc_d    = 1'b0;
              out_byte_d  = pg1_cmd;
            end
          end
        end
      end
      DATA: begin
        if (bus.out_ready) begin
          state_d     = after_q;
          out_valid_d = 1'b0;
          if (after_q == CMD_PAGE) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b0;
            out_byte_d  = pg1_cmd;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      after_q     <= IDLE;
      font_q      <= 6'd0;
      page_q      <= 3'd0;
      col_q       <= 7'd0;
      row_q       <= 1'b0;
      idx_q       <= 4'd0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_dc_q    <= 1'b0;
      out_byte_q  <= 8'd0;
      err_q       <= 1'b0;
`ifdef OLED_INVERT_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      after_q     <= after_d;
      font_q      <= font_d;
      page_q      <= page_d;
      col_q       <= col_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_dc_q    <= out_dc_d;
      out_byte_q  <= out_byte_d;
      err_q       <= err_d;
`ifdef OLED_INVERT_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_dc    = out_dc_q;
  assign bus.out_byte  = out_byte_q;
  assign rom_font_row  = row_q;
  assign rom_font_sel  = font_q;
  assign rom_index     = {5'b00000, idx_q};
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_oled_glyph_sequencer.sv
// Self-checking bench for oled_glyph_sequencer: a latency-modelled font ROM,
// a glyph-level reference model feeding an expected queue, and a stream monitor.
module tb_oled_glyph_sequencer;
  import oled_pkg::*;

  localparam int ROM_LAT = 1;

  logic       clk;
  logic       rst_n;
  logic       rom_font_row;
  logic [5:0] rom_font_sel;
  logic [8:0] rom_index;
  logic [7:0] rom_data;
  logic       busy, done, err;
  state_e     dbg_state;

  oled_glyph_sequencer_if bus_if ();

  oled_glyph_sequencer #(
    .PAGE_COUNT (8),
    .COL_COUNT  (128),
    .ROM_LATENCY(ROM_LAT)
  ) dut (
    .sys_clk     (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .rom_font_row(rom_font_row),
    .rom_font_sel(rom_font_sel),
    .rom_index   (rom_index),
    .rom_data    (rom_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- font ROM model ----------------
  logic [7:0] rom_mem [0:15][0:1][0:15];
  logic [7:0] rom_pipe [0:2];

  always @(posedge clk) begin
    rom_pipe[0] <= rom_mem[rom_font_sel[3:0]][rom_font_row][rom_index[3:0]];
    rom_pipe[1] <= rom_pipe[0];
    rom_pipe[2] <= rom_pipe[1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int hs_cnt     = 0;
  bit stall_mode = 1'b0;

  // Expected stream of one glyph, built from the drawing rules directly.
  task automatic push_model(input int sel, input int page, input int col, input bit inv);
    int w;
    if (sel > 14) return;
    w = ((sel >= 4 && sel <= 9) || sel == 11) ? 16 : 8;
    for (int row = 0; row < 2; row++) begin
      if (row == 1 && page + 1 >= 8) break;
      exp_q.push_back({1'b0, 8'(8'hB0 + page + row)});
      exp_q.push_back({1'b0, 8'(col % 16)});
      exp_q.push_back({1'b0, 8'(8'h10 + col / 16)});
      for (int i = 0; i < w; i++) begin
        if (col + i < 128)
          exp_q.push_back({1'b1, rom_mem[sel][row][i] ^ (inv ? 8'hFF : 8'h00)});
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit         hold_v = 1'b0;
  logic [8:0] hold_word;
  logic [8:0] got;
  logic [8:0] want;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      got = {bus_if.out_dc, bus_if.out_byte};
      if (hold_v) begin
        compared++;
        if (!(bus_if.out_valid && got == hold_word)) begin
          mismatched++;
          $display("FAIL stall_hold: valid=%0b dc/byte=%h required valid=1 dc/byte=%h",
                   bus_if.out_valid, got, hold_word);
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (bus_if.out_valid && bus_if.out_ready) begin
        hs_cnt++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL stream_extra: got dc/byte=%h required no byte", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            mismatched++;
            $display("FAIL stream_byte: got dc/byte=%h required %h", got, want);
          end
        end
        hold_v = 1'b0;
      end else if (bus_if.out_valid) begin
        hold_v    = 1'b1;
        hold_word = got;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic do_req(input int sel, input int page, input int col, input bit inv);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_ready_wait", {31'd0, ok}, 32'd1);
    bus_if.req_valid    = 1'b1;
    bus_if.req_font_sel = 6'(sel);
    bus_if.req_page     = 3'(page);
    bus_if.req_col      = 7'(col);
`ifdef OLED_INVERT_EN
    bus_if.req_invert   = inv;
`endif
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("glyph_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_glyph(input int sel, input int page, input int col, input bit inv,
                           output int n_hs);
    int d0, e0, h0;
    d0 = done_cnt;
    e0 = err_cnt;
    h0 = hs_cnt;
    push_model(sel, page, col, inv);
    do_req(sel, page, col, inv);
    if (sel > 14) begin
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_ready", {31'd0, bus_if.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("err_one_cycle", {31'd0, err}, 32'd0);
    end
    wait_idle();
    check("done_count", 32'(done_cnt - d0), (sel > 14) ? 32'd0 : 32'd1);
    check("err_count", 32'(err_cnt - e0), (sel > 14) ? 32'd1 : 32'd0);
    n_hs = hs_cnt - h0;
  endtask

  // ---------------- main sequence ----------------
  int  n;
  bit  inv_r;
  bit  ok;
  logic [7:0] f_row0 [0:7];
  logic [7:0] f_row1 [0:7];

  initial begin
    f_row0 = '{8'h08, 8'hF8, 8'h88, 8'h88, 8'hE8, 8'h08, 8'h10, 8'h00};
    f_row1 = '{8'h20, 8'h3F, 8'h20, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 16; i++)
          rom_mem[s][r][i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      rom_mem[0][0][i] = f_row0[i];
      rom_mem[0][1][i] = f_row1[i];
    end
    rom_mem[4][0][0] = 8'h10;
    rom_mem[4][1][0] = 8'h04;

    rst_n               = 1'b0;
    bus_if.req_valid    = 1'b0;
    bus_if.req_font_sel = 6'd0;
    bus_if.req_page     = 3'd0;
    bus_if.req_col      = 7'd0;
`ifdef OLED_INVERT_EN
    bus_if.req_invert   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_dc", {31'd0, bus_if.out_dc}, 32'd0);
    check("rst_out_byte", {24'd0, bus_if.out_byte}, 32'd0);
    check("rst_rom", {16'd0, rom_font_row, rom_font_sel, rom_index}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);

    // Directed cases from the drawing rules.
    run_glyph(0, 2, 10, 1'b0, n);
    check("f_handshakes", 32'(n), 32'd22);
    run_glyph(4, 0, 0, 1'b0, n);
    check("wide_handshakes", 32'(n), 32'd38);
    run_glyph(6, 3, 120, 1'b0, n);
    check("colclip_handshakes", 32'(n), 32'd22);
    run_glyph(0, 7, 0, 1'b0, n);
    check("pageclip_handshakes", 32'(n), 32'd11);
    run_glyph(20, 1, 5, 1'b0, n);
    check("err_handshakes", 32'(n), 32'd0);
    run_glyph(11, 1, 30, 1'b0, n);
    stall_mode = 1'b1;
    run_glyph(11, 1, 30, 1'b0, n);
    check("stall_handshakes", 32'(n), 32'd38);

    // Randomised glyphs with random back-pressure.
    for (int t = 0; t < 24; t++) begin
      stall_mode = 1'($urandom_range(0, 1));
`ifdef OLED_INVERT_EN
      inv_r = 1'($urandom_range(0, 1));
`else
      inv_r = 1'b0;
`endif
      run_glyph(int'($urandom_range(0, 20)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 127)), inv_r, n);
    end

    // Reset in the middle of a glyph's data phase.
    stall_mode = 1'b1;
    push_model(11, 2, 40, 1'b0);
    do_req(11, 2, 40, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      if (dbg_state == DATA) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_data", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_mode = 1'b0;
    run_glyph(0, 2, 10, 1'b0, n);
    check("post_rst_handshakes", 32'(n), 32'd22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
